alu_nibble_sequencer: RTL
=========================

# alu_nibble_sequencer

Multi-cycle wide ALU that runs a 74181-style function across a WIDTH-bit operand one 4-bit slice per clock. Each slice's carry is registered and fed to the next slice. It sits downstream of the per-bit generate/propagate term logic and consumes those terms. It performs the carry resolution, result formation and result hand-off that the term logic leaves open. Operands enter and results leave on valid/ready handshakes.

## Interface
- WIDTH, 16: operand/result width. It must be a multiple of 4 and at least 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request. High exactly when the state is IDLE.
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- S  in  4  function select (74181 encoding)
- M  in  1  mode: 1 = logic, 0 = arithmetic
- cin  in  1  active-high carry into nibble 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- F  out  WIDTH  result
- cout  out  1  carry out of the top nibble. Always 0 when M=1.
- eq  out  1  high when all bits of F are 1 (the 74181 A=B flag)

## Operation
- Per-bit terms:
  - g = A&B&S[3] | A&~B&S[2]
  - p = A | B&S[0] | ~B&S[1]
  - h = p & ~g
- Arithmetic mode (M=0):
  - F_i = h_i ^ c_i
  - c_{i+1} = g_i | p_i&c_i
  - c_0 of nibble 0 = cin. Each later nibble's c_0 is the registered carry from the previous nibble.
- Logic mode (M=1):
  - F_i = ~h_i
  - Carries are ignored and cout = 0.
- Function encodings used by the bench:
  - S=1001, M=0 → A+B+cin
  - S=0110, M=0 → A+~B+cin, which is A−B when cin=1
  - S=0110, M=1 → A^B
- States:
  - IDLE: in_ready=1. On in_valid, capture A, B, S, M and cin, clear the nibble index, and go to RUN.
  - RUN: each cycle, compute nibble idx, write F[4*idx+3:4*idx], and register its carry. After nibble WIDTH/4−1, latch cout and eq and go to DONE.
  - DONE: out_valid=1 and F/cout/eq are held stable. On out_ready, go to IDLE.
- Inputs are sampled only at the accept edge. Changes to A/B/S/M/cin after that edge have no effect on the operation in flight.
- in_valid in RUN or DONE is ignored. No request is queued.
- Nibble index width is clog2(WIDTH/4), with a minimum of 1 bit. The index wraps only through the reset at accept, never by overflow.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 while rst_n is low
  - out_valid = 0, F = 0, cout = 0, eq = 0
  - internal carry = 0, index = 0
- Latency: an accept on edge k raises out_valid after edge k+WIDTH/4. That is 4 cycles at the default WIDTH.
- Release and throughput:
  - An out_ready on edge j drops out_valid and raises in_ready after edge j.
  - Minimum spacing between accepts is WIDTH/4+2 cycles.
- The out_valid & out_ready handshake completes on the same edge. out_valid is not held one extra cycle.
- F, cout and eq are undefined-but-stable outside DONE. The bench checks them only while out_valid=1.
- Reset asserted mid-RUN or mid-DONE:
  - aborts immediately and asynchronously
  - nothing is emitted
  - the first operation after reset is unaffected by the aborted one

## Structure
- Shared package alu_pkg holds:
  - NIB_W = 4
  - the state enum {IDLE, RUN, DONE}
  - S encodings S_ADD=4'b1001 and S_SUB=4'b0110
- Sub-module alu_nibble_slice is combinational. It takes 4-bit a, b, s, m and c0, and produces the 4-bit f and carry out c4. Its carries are computed lookahead-style inside the slice. The sequencer instantiates it once.

## Test plan
- Add, WIDTH=16: A=16'h1234, B=16'h0FCC, S=1001, M=0, cin=0 → F=16'h2200, cout=0, eq=0, with out_valid exactly 4 cycles after accept.
- Full ripple: A=16'hFFFF, B=16'h0001, add → F=16'h0000, cout=1. This checks carry transfer across all four nibble boundaries.
- Subtract and compare:
  - A=16'h0005, B=16'h0007, S=0110, M=0, cin=1 → F=16'hFFFE, cout=0.
  - A=B=16'h5A5A, cin=0 → F=16'hFFFF, eq=1, cout=0.
- Logic XOR: A=16'h00FF, B=16'h0F0F, S=0110, M=1, cin=1 → F=16'h0FF0, cout=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands. F, cout and eq must stay stable and in_ready must stay 0.
  - Then raise out_ready. One cycle later in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 nibbles of an add. All outputs go to reset values immediately. The next add, 16'h0001+16'h0001, yields 16'h0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial 74181-style ALU.
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit 74181-style slice: generate/propagate terms, lookahead carries, result.
module alu_nibble_slice
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             c0_i,
  output logic [NIB_W-1:0] f_o,
  output logic             c4_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] h;
  logic [3:0] c;

  assign g = (a_i & b_i & {4{s_i[3]}}) | (a_i & ~b_i & {4{s_i[2]}});
  assign p = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
  assign h = p & ~g;

  // Two-level lookahead: every carry is a flat sum of products of g/p and c0.
  assign c[0] = c0_i;
  assign c[1] = g[0] | (p[0] & c0_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
  assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0_i);

  assign f_o = m_i ? ~h : (h ^ c);

endmodule

// File: rtl/alu_nibble_sequencer.sv
// WIDTH-bit ALU evaluated one nibble per clock; carry is registered between nibbles.
// Result is held in DONE until out_ready_i; new requests are taken only in IDLE.
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o,
  output logic             eq_o
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             eq_q, eq_d;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] f_nib;
  logic             c4;
  logic [WIDTH-1:0] f_run;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBS; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*NIB_W +: NIB_W];
        b_nib = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  alu_nibble_slice u_slice (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .s_i  (s_q),
    .m_i  (m_q),
    .c0_i (c_q),
    .f_o  (f_nib),
    .c4_o (c4)
  );

  always_comb begin
    f_run = f_q;
    for (int n = 0; n < NIBS; n++) begin
      if (idx_q == IDX_W'(n)) begin
        f_run[n*NIB_W +: NIB_W] = f_nib;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    c_d     = c_q;
    idx_d   = idx_q;
    f_d     = f_q;
    cout_d  = cout_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          s_d     = s_i;
          m_d     = m_i;
          c_d     = cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        f_d = f_run;
        c_d = c4;
        if (idx_q == LAST_IDX) begin
          cout_d  = ~m_q & c4;
          eq_d    = &f_run;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      eq_q    <= eq_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign f_o         = f_q;
  assign cout_o      = cout_q;
  assign eq_o        = eq_q;

endmodule
